// File: rtl/exception_sequencer.sv
// Exception-path sequencer: prioritises EX overflow / ID undefined-instruction, captures EPC/Cause,
// drives pipeline flushes and PC redirect, and sequences ERET. Optional counter under `EXC_COUNT_EN.
module exception_sequencer #(
  parameter logic [31:0] HANDLER_VEC  = 32'h8000_0180,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ovf_ex,
  input  logic        undef_id,
  input  logic        eret_id,
  input  logic [31:0] pc_ex,
  input  logic [31:0] pc_id,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        pc_sel_vec,
  output logic        pc_sel_epc,
  output logic [31:0] handler_pc,
  output logic [31:0] epc,
  output logic        cause,
  output logic        exl,
  output logic        nested_err,
  output logic [15:0] exc_count
);

  typedef enum logic [1:0] {IDLE, FLUSH, HANDLER} state_t;

  // Extra flush cycles after the detection cycle, stored as a count-down to zero.
  localparam logic [1:0] FLUSH_EXTRA = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t      state_q, state_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [31:0] epc_q, epc_d;
  logic        cause_q, cause_d;
  logic        exl_q, exl_d;
  logic        nerr_q, nerr_d;
  logic        if_id_c, id_ex_c, ex_mem_c, vec_c, sepc_c;
  logic        take_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= 2'd0;
      epc_q   <= 32'd0;
      cause_q <= 1'b0;
      exl_q   <= 1'b0;
      nerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      nerr_q  <= nerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    exl_d    = exl_q;
    nerr_d   = nerr_q;
    if_id_c  = 1'b0;
    id_ex_c  = 1'b0;
    ex_mem_c = 1'b0;
    vec_c    = 1'b0;
    sepc_c   = 1'b0;
    take_c   = 1'b0;
    case (state_q)
      IDLE: begin
        // exl is always 0 here, so an ERET in IDLE is illegal and treated as undefined.
        if (ovf_ex) begin
          {if_id_c, id_ex_c, ex_mem_c, vec_c} = 4'b1111;
          epc_d   = pc_ex - 32'd4;
          cause_d = 1'b1;
          exl_d   = 1'b1;
          take_c  = 1'b1;
        end else if (undef_id || eret_id) begin
          {if_id_c, id_ex_c, ex_mem_c, vec_c} = 4'b1101;
          epc_d   = pc_id - 32'd4;
          cause_d = 1'b0;
          exl_d   = 1'b1;
          take_c  = 1'b1;
        end
        if (take_c) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_EXTRA;
          end else begin
            state_d = HANDLER;
          end
        end
      end
      FLUSH: begin
        // Repeat the detection-cycle pattern; EX/MEM is flushed only for an overflow.
        if_id_c  = 1'b1;
        id_ex_c  = 1'b1;
        ex_mem_c = cause_q;
        if (ovf_ex || undef_id || eret_id) nerr_d = 1'b1;
        if (fcnt_q == 2'd0) state_d = HANDLER;
        else                fcnt_d  = fcnt_q - 2'd1;
      end
      HANDLER: begin
        if (ovf_ex || undef_id) nerr_d = 1'b1;
        if (eret_id) begin
          if_id_c = 1'b1;
          sepc_c  = 1'b1;
          exl_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mealy outputs are forced low while reset is held so nothing asserts during reset.
  assign if_id_flush  = ~reset & if_id_c;
  assign id_ex_flush  = ~reset & id_ex_c;
  assign ex_mem_flush = ~reset & ex_mem_c;
  assign pc_sel_vec   = ~reset & vec_c;
  assign pc_sel_epc   = ~reset & sepc_c;
  assign handler_pc   = reset ? 32'd0 : HANDLER_VEC;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign exl          = exl_q;
  assign nested_err   = nerr_q;

`ifdef EXC_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (take_c && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign exc_count = cnt_q;
`else
  assign exc_count = 16'h0000;
`endif

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Sequencing controller for the pipeline's exception path.
- Takes raw overflow (EX) and undefined-instruction (ID) flags and prioritises them.
- Captures EPC/Cause into registers and drives the IF/ID, ID/EX and EX/MEM flushes for a programmable number of cycles.
- Redirects fetch to the handler vector, masks nested exceptions while the handler runs, and sequences the ERET return to EPC.

Parameters:
- HANDLER_VEC, 32'h8000_0180, fetch address of the exception handler.
- FLUSH_CYCLES, 1, cycles (1..3) that flush outputs stay asserted per exception.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ovf_ex  in  1  arithmetic overflow from the instruction in EX
- undef_id  in  1  undefined opcode decoded in ID
- eret_id  in  1  ERET decoded in ID
- pc_ex  in  32  PC+4 of the instruction in EX
- pc_id  in  32  PC+4 of the instruction in ID
- if_id_flush  out  1  flush the IF/ID register
- id_ex_flush  out  1  flush the ID/EX register
- ex_mem_flush  out  1  flush the EX/MEM register
- pc_sel_vec  out  1  PC mux selects handler_pc
- pc_sel_epc  out  1  PC mux selects epc
- handler_pc  out  32  constant HANDLER_VEC
- epc  out  32  registered exception PC
- cause  out  1  1 = overflow, 0 = undefined instruction
- exl  out  1  exception level; handler active
- nested_err  out  1  sticky: an exception arrived while exl=1
- exc_count  out  16  exception counter (see optional feature)

Behaviour:
- States: IDLE, FLUSH, HANDLER.
- Reset (async, any state): state=IDLE; all outputs 0, including epc, cause, exl, nested_err and exc_count. No X values are ever driven.
- IDLE detection is Mealy, acting in the same cycle the flag is high:
  - ovf_ex=1 (highest priority): if_id_flush=id_ex_flush=ex_mem_flush=1, pc_sel_vec=1. At the edge: epc<=pc_ex-4, cause<=1, exl<=1.
  - else undef_id=1, or eret_id=1 while exl=0 (ERET outside a handler is illegal): if_id_flush=id_ex_flush=1, ex_mem_flush=0, pc_sel_vec=1. At the edge: epc<=pc_id-4, cause<=0, exl<=1.
  - Next state is FLUSH if FLUSH_CYCLES>1, else HANDLER.
- EPC arithmetic is 32-bit modulo: pc=0 gives epc=32'hFFFF_FFFC.
- FLUSH state:
  - An internal counter holds the same flush pattern as the detection cycle for FLUSH_CYCLES-1 further cycles.
  - pc_sel_vec=0 in FLUSH.
  - Move to HANDLER when the count expires.
- HANDLER state:
  - exl=1; flushes and pc_sel_* are 0.
  - ovf_ex or undef_id is not taken: epc and cause are unchanged, nested_err<=1 (sticky until reset), no flush.
  - eret_id=1: if_id_flush=1 and pc_sel_epc=1 in that cycle. At the edge: exl<=0, state<=IDLE. epc and cause are retained.
  - eret_id together with ovf_ex in the same cycle: ERET is taken and nested_err is set.
- FLUSH ignores all flags; nested_err is set if any flag is high.
- Latency: flush and redirect in the detection cycle (0 cycles); epc/cause/exl valid on the next cycle.
- Back-to-back: an exception flag in the cycle immediately after ERET returns to IDLE is taken normally.

Optional Feature:
- Macro EXC_COUNT_EN.
- Defined: exc_count increments by 1 on each accepted exception (IDLE detection edge) and saturates at 16'hFFFF. Nested or ignored flags and ERET do not count. Reset clears it.
- Undefined: counter logic is omitted; exc_count is tied to 16'h0000.

Test Plan:
- Reset asserted mid-FLUSH (FLUSH_CYCLES=3) -> outputs all 0 immediately and asynchronously, state=IDLE, exl=0.
- IDLE, ovf_ex=1 and undef_id=1 together, pc_ex=32'h0000_0108 -> all three flushes=1 and pc_sel_vec=1 in that cycle; next cycle epc=32'h0000_0104, cause=1, exl=1.
- undef_id=1, pc_id=32'h0000_0000 -> ex_mem_flush=0, if_id/id_ex flush=1; epc=32'hFFFF_FFFC, cause=0.
- FLUSH_CYCLES=3, ovf_ex pulse -> flushes high for exactly 3 cycles, pc_sel_vec for 1 cycle; then HANDLER.
- In HANDLER, undef_id pulse, then eret_id -> nested_err=1, epc unchanged. In the ERET cycle pc_sel_epc=1 and if_id_flush=1; next cycle exl=0. nested_err stays 1.
- eret_id in IDLE with pc_id=32'h40 -> taken as undef: epc=32'h3C, cause=0. With EXC_COUNT_EN, exc_count=1.
